// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and types for the sequential multiplier family.
//   MULT_W  operand width (matches cla_16bit)
//   CNT_W   iteration counter width (MULT_W iterations)
//   PROD_W  product width
//   mult_state_t  control FSM encoding {IDLE, RUN, DONE}
package mult_pkg;

   localparam int MULT_W = 16;
   localparam int CNT_W  = 4;
   localparam int PROD_W = 2 * MULT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/seq_mult16_if.sv
// seq_mult16_if: request/response bundle for seq_mult16.
//   start    request, only sampled while the multiplier is IDLE
//   a, b     multiplicand / multiplier, latched on the accepting edge
//   busy     high from the accepting edge until the return to IDLE
//   done     one-cycle completion pulse, product valid in that cycle
//   product  32-bit result, held until the next completion
//   state    FSM state, exported for observation
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is IDLE; start at any other time is dropped, never queued. There is
// no back-pressure on the result: done is a pulse, product is level-held.
interface seq_mult16_if;
   import mult_pkg::*;

   logic                start;
   logic [MULT_W-1:0]   a;
   logic [MULT_W-1:0]   b;
   logic                busy;
   logic                done;
   logic [PROD_W-1:0]   product;
   mult_state_t         state;

   modport master (
      output start, a, b,
      input  busy, done, product, state
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, state
   );

endinterface

// File: rtl/cla_16bit.sv
// cla_16bit: 16-bit carry-lookahead adder built from four 4-bit groups.
//   a, b   addends
//   c0     carry in
//   sum    a + b + c0, low 16 bits
//   c16    carry out
module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c0,
   output logic [15:0] sum,
   output logic        c16
);

   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  gc;
   logic [15:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Group propagate/generate per nibble.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
   end

   // Second-level lookahead: group carries straight from c0.
   assign gc[0] = c0;
   assign gc[1] = gg[0] | (gp[0] & c0);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & c0);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & c0);

   // Bit carries inside each group, expanded from that group's carry in.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
   end

   assign sum = p ^ c;
   assign c16 = gc[4];

endmodule

// File: rtl/seq_mult16.sv
// seq_mult16: unsigned 16x16 shift-add multiplier, one partial product per
// cycle through a single cla_16bit. Fixed latency: accept at E0, iterations
// at E1..E16, done pulse in the cycle after E16, IDLE again at E17.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (aborts any operation)
//   bus   seq_mult16_if.slave: start/a/b in, busy/done/product/state out
module seq_mult16
   import mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   seq_mult16_if.slave  bus
);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             c16;

   // Multiplier LSB selects whether this iteration adds the multiplicand.
   assign addend = acc_lo[0] ? mcand : '0;

   cla_16bit u_cla (
      .a   (acc_hi),
      .b   (addend),
      .c0  (1'b0),
      .sum (sum),
      .c16 (c16)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.state   <= IDLE;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.product <= '0;
         mcand       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         cnt         <= '0;
      end else begin
         case (bus.state)
            IDLE: begin
               if (bus.start) begin
                  mcand     <= bus.a;
                  acc_lo    <= bus.b;
                  acc_hi    <= '0;
                  cnt       <= '0;
                  bus.busy  <= 1'b1;
                  bus.state <= RUN;
               end
            end
            RUN: begin
               // 33-bit {c16, sum, acc_lo} shifted right by one; the carry
               // becomes the new MSB so nothing is ever lost.
               acc_hi <= {c16, sum[WIDTH-1:1]};
               acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(MULT_W - 1)) begin
                  bus.product <= {c16, sum, acc_lo[WIDTH-1:1]};
                  bus.done    <= 1'b1;
                  bus.state   <= DONE;
               end
            end
            DONE: begin
               bus.done  <= 1'b0;
               bus.busy  <= 1'b0;
               bus.state <= IDLE;
            end
            default: begin
               bus.done  <= 1'b0;
               bus.busy  <= 1'b0;
               bus.state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: self-checking bench for seq_mult16. Expected products come
// from plain 32-bit multiplication; timing expectations from the documented
// latency (done 16 edges after accept, busy for 17 cycles).
module tb_seq_mult16;
   import mult_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_prod;

   seq_mult16_if bus ();

   seq_mult16 #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   // Called at a falling edge with the DUT idle. Issues one request, then
   // scrambles a/b after the accept edge. Returns at the falling edge of the
   // first idle cycle after completion, so a follow-up call hits E18.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] hold,
                         output logic [31:0] p, output int done_edge,
                         output int busy_cycles, output int done_cycles,
                         output bit stable);
      p = '0; done_edge = -1; busy_cycles = 0; done_cycles = 0; stable = 1'b1;
      bus.start = 1'b1; bus.a = x; bus.b = y;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            done_cycles++;
            if (done_edge < 0) begin
               done_edge = k;
               p = bus.product;
            end
         end else if (done_edge < 0 && bus.product !== hold) begin
            stable = 1'b0;
         end
         if (k > 0 && !bus.busy) break;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
      checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", bus.product); end
      checks++; if (bus.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", bus.state); end
      rst = 1'b0;
      last_prod = '0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] p; int de, bc, dc; bit st;
      run_op(16'h0003, 16'h0005, last_prod, p, de, bc, dc, st);
      checks++; if (p !== 32'h0000000F) begin failures++; $display("FAIL basic_product got=%h exp=0000000f", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL basic_done_edge got=%0d exp=16", de); end
      checks++; if (bc !== 17) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=17", bc); end
      checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_cycles got=%0d exp=1", dc); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL basic_hold got=changed exp=stable"); end
      last_prod = 32'h0000000F;
   endtask

   task automatic test_all_ones();
      logic [31:0] p; int de, bc, dc; bit st;
      run_op(16'hFFFF, 16'hFFFF, last_prod, p, de, bc, dc, st);
      checks++; if (p !== 32'hFFFE0001) begin failures++; $display("FAIL ones_product got=%h exp=fffe0001", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL ones_done_edge got=%0d exp=16", de); end
      last_prod = 32'hFFFE0001;
   endtask

   task automatic test_zero_and_shift();
      logic [31:0] p; int de, bc, dc; bit st;
      run_op(16'h0000, 16'hFFFF, last_prod, p, de, bc, dc, st);
      checks++; if (p !== 32'h0) begin failures++; $display("FAIL zero_product got=%h exp=00000000", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL zero_done_edge got=%0d exp=16", de); end
      checks++; if (bc !== 17) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=17", bc); end
      last_prod = 32'h0;
      run_op(16'h8000, 16'h0002, last_prod, p, de, bc, dc, st);
      checks++; if (p !== 32'h00010000) begin failures++; $display("FAIL shift_product got=%h exp=00010000", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL shift_done_edge got=%0d exp=16", de); end
      last_prod = 32'h00010000;
   endtask

   task automatic test_ignored_start();
      logic [31:0] p; int de, bc, dc; bit late_busy;
      logic [31:0] p2; int de2, bc2, dc2; bit st2;
      p = '0; de = -1; bc = 0; dc = 0; late_busy = 1'b0;
      bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0101;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (bus.busy) bc++;
         if (bus.busy && k >= 17) late_busy = 1'b1;
         if (bus.done) begin
            dc++;
            if (de < 0) begin de = k; p = bus.product; end
         end
         // Sampled at E5 (RUN) and at E17 (DONE): both must be dropped.
         if (k == 4 || k == 16) begin bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; end
         if (k == 5 || k == 17) bus.start = 1'b0;
      end
      checks++; if (p !== 32'h0000FFFF) begin failures++; $display("FAIL ignore_product got=%h exp=0000ffff", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL ignore_done_edge got=%0d exp=16", de); end
      checks++; if (dc !== 1) begin failures++; $display("FAIL ignore_done_cycles got=%0d exp=1", dc); end
      checks++; if (bc !== 17) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=17", bc); end
      checks++; if (late_busy !== 1'b0) begin failures++; $display("FAIL ignore_not_queued got=busy exp=idle"); end
      last_prod = 32'h0000FFFF;
      run_op(16'd7, 16'd9, last_prod, p2, de2, bc2, dc2, st2);
      checks++; if (p2 !== 32'd63) begin failures++; $display("FAIL ignore_next_product got=%h exp=0000003f", p2); end
      last_prod = 32'd63;
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] p; int de, bc, dc; bit st;
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", bus.done); end
      checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL midrst_product got=%h exp=0", bus.product); end
      checks++; if (bus.state !== IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=IDLE", bus.state); end
      @(negedge clk);
      rst = 1'b0;
      last_prod = '0;
      @(negedge clk);
      run_op(16'h1234, 16'h5678, last_prod, p, de, bc, dc, st);
      checks++; if (p !== 32'h06260060) begin failures++; $display("FAIL midrst_rerun got=%h exp=06260060", p); end
      checks++; if (de !== 16) begin failures++; $display("FAIL midrst_done_edge got=%0d exp=16", de); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL midrst_hold got=changed exp=stable"); end
      last_prod = 32'h06260060;
   endtask

   task automatic test_back_to_back();
      logic [31:0] p, exp_p; int de, bc, dc; bit st;
      logic [15:0] x, y;
      for (int n = 0; n < 1000; n++) begin
         x = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
         y = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
         exp_q.push_back(32'(x) * 32'(y));
         run_op(x, y, last_prod, p, de, bc, dc, st);
         exp_p = exp_q.pop_front();
         checks++; if (p !== exp_p) begin failures++; $display("FAIL b2b_product n=%0d a=%h b=%h got=%h exp=%h", n, x, y, p, exp_p); end
         checks++; if (de !== 16) begin failures++; $display("FAIL b2b_done_edge n=%0d got=%0d exp=16", n, de); end
         checks++; if (st !== 1'b1) begin failures++; $display("FAIL b2b_hold n=%0d got=changed exp=stable", n); end
         last_prod = exp_p;
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_zero_and_shift();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
